polar64_dec_arbiter: RTL and testbench
======================================

# polar64_dec_arbiter

Round-robin arbiter that shares one `polar64_crc16_decoder` among `NREQ` requesters. Each requester offers a 64-bit received word over a valid/ready handshake. The arbiter sequences the decoder's one-cycle `start` / `done` protocol and returns `data_out` and `valid` to the granted requester over a valid/ready response channel. An optional watchdog (`POLAR_DEC_ARB_TIMEOUT_EN`) converts a missing `done` into an error response.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `TIMEOUT`, default 15: WAIT cycles allowed for `dec_done`; must be ≥ 1.

**Ports**
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted (one-hot or zero).
- `req_rx`  in  64*NREQ  received words; requester i at `[64*i +: 64]`.
- `rsp_valid`  out  NREQ  response available (one-hot or zero).
- `rsp_ready`  in  NREQ  requester takes the response.
- `rsp_data`  out  24  decoded payload.
- `rsp_ok`  out  1  decoder `valid` (CRC pass).
- `rsp_timeout`  out  1  watchdog fired.
- `dec_start`  out  1  decoder start pulse.
- `dec_rx`  out  64  decoder input word.
- `dec_done`  in  1  decoder completion pulse.
- `dec_data_out`  in  24  decoder payload.
- `dec_valid`  in  1  decoder CRC-pass flag.
- `busy`  out  1  high in every state except IDLE.

## Operation

**FSM states:** IDLE, ISSUE, WAIT, RESP.

**IDLE**
- Grant g is the first requester with `req_valid` set, searching upward from `ptr` with modulo-`NREQ` wrap.
- `req_ready[g]` is driven combinationally in the same cycle; all other `req_ready` bits stay 0.
- On the handshake: latch `req_rx[g]` into `dec_rx`, latch g, then go to ISSUE.
- With no `req_valid`, stay in IDLE.

**ISSUE**
- `dec_start`=1 for exactly this one cycle.
- Clear the wait counter, then go to WAIT.

**WAIT**
- The counter increments each cycle, starting at 1 in the first WAIT cycle.
- When `dec_done`=1:
  - capture `rsp_data`=`dec_data_out`, `rsp_ok`=`dec_valid`, `rsp_timeout`=0;
  - go to RESP.
- With the macro defined, if the counter equals `TIMEOUT` and `dec_done`=0:
  - capture `rsp_data`=0, `rsp_ok`=0, `rsp_timeout`=1;
  - go to RESP.
- If `dec_done` arrives in the same cycle as the timeout, `dec_done` wins.

**RESP**
- `rsp_valid[g]`=1, held until `rsp_ready[g]`=1.
- On that handshake: `ptr`=(g+1) mod `NREQ`, then go to IDLE.
- `rsp_ready` bits of non-granted requesters are ignored.

**General rules**
- `dec_rx` stays stable from ISSUE until the next IDLE acceptance.
- `dec_done` is ignored outside WAIT; a late `done` after a timeout is therefore discarded.
- `rsp_data`, `rsp_ok` and `rsp_timeout` hold their last captured values outside RESP.
- Width rules:
  - grant index and `ptr` are `$clog2(NREQ)` bits;
  - wait counter is `$clog2(TIMEOUT+1)` bits and saturates, never wraps.

## Timing

**Reset**
- Every output is 0: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_ok`, `rsp_timeout`, `dec_start`, `dec_rx`, `busy`.
- State=IDLE, `ptr`=0, counter=0.

**Reset mid-operation**
- At the first rising edge with `rst_n`=0, the arbiter enters IDLE and drops the in-flight request without a response.
- `dec_start` is never asserted during reset.

**Latency** (handshake in cycle 0; decoder latency L = cycles from the start-sampling edge to `done` high)
- ISSUE: cycle 1.
- `dec_done` seen: cycle 1+L.
- `rsp_valid`: cycle 2+L.
- Timeout response: cycle 2+`TIMEOUT`.

**Throughput**
- Minimum L+3 cycles per transaction with `rsp_ready` held high.
- The next acceptance can occur in the cycle after the RESP handshake.

**Simultaneous requests:** exactly one grant per IDLE cycle, in round-robin order.

**Request-side rules**
- Dropping `req_valid` before acceptance is permitted.
- `req_rx` is sampled only in the handshake cycle.

## Configuration

**`POLAR_DEC_ARB_TIMEOUT_EN`**
- Defined: watchdog active as described in Operation.
- Undefined:
  - WAIT exits only on `dec_done` and waits indefinitely;
  - `rsp_timeout` is tied to 0;
  - the counter logic is removed.

## Test plan

1. **Single clean request:** requester 0 offers the clean codeword of 24'hABCDEF; decoder L=5 → `dec_start` in cycle 1, `rsp_valid[0]` in cycle 7, `rsp_data`=ABCDEF, `rsp_ok`=1, `rsp_timeout`=0.
2. **Round-robin order:** all 4 `req_valid` raised together after reset → grants 0,1,2,3 in order. Then requesters 0 and 2 raise `req_valid` together with `ptr`=0 → grants 0 then 2.
3. **Uncorrectable word:** 4-bit-error codeword → `rsp_ok`=0, `rsp_timeout`=0, response latency unchanged.
4. **Missing done:** stub decoder never asserts `done`, `TIMEOUT`=15.
   - Macro defined → `rsp_valid` in cycle 17, `rsp_timeout`=1, `rsp_data`=0.
   - Macro undefined → `busy` stays 1 and `rsp_valid` stays 0 after 100 cycles.
5. **Response backpressure:** `rsp_ready` held low 5 cycles in RESP → `rsp_valid` and `rsp_data` stable, no `dec_start`, all `req_ready`=0.
6. **Reset mid-operation:** `rst_n` low during WAIT → outputs 0 at the next edge. A subsequent stale `dec_done` produces no response. The next request is granted to requester 0.

Source files
------------

// File: rtl/polar64_dec_arbiter.sv
// Round-robin arbiter sharing one polar64 CRC16 decoder among NREQ requesters.
// Optional dec_done watchdog is compiled in when POLAR_DEC_ARB_TIMEOUT_EN is defined.
module polar64_dec_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_rx,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [23:0]          rsp_data,
    output logic                 rsp_ok,
    output logic                 rsp_timeout,
    output logic                 dec_start,
    output logic [63:0]          dec_rx,
    input  logic                 dec_done,
    input  logic [23:0]          dec_data_out,
    input  logic                 dec_valid,
    output logic                 busy
);
    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("polar64_dec_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                      state;
    logic [IDX_W-1:0]            ptr;
    logic [IDX_W-1:0]            gnt;
    logic [IDX_W-1:0]            grant_idx;
    logic [IDX_W-1:0]            cand;
    logic                        grant_found;
    logic                        start_q;
    logic [NREQ-1:0]             gnt_onehot;
    logic [NREQ-1:0]             grant_onehot;
    logic [NREQ-1:0][63:0]       rx_words;

`ifdef POLAR_DEC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0]            cnt;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign rx_words = req_rx;

    // First requesting index at or above ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_idx] = grant_found;
        gnt_onehot              = '0;
        gnt_onehot[gnt]         = 1'b1;
    end

    assign req_ready = (rst_n && state == IDLE) ? grant_onehot : '0;
    assign dec_start = start_q & rst_n;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            start_q   <= 1'b0;
            dec_rx    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_ok    <= 1'b0;
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        dec_rx  <= rx_words[grant_idx];
                        gnt     <= grant_idx;
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
                    // Loaded with 1 so the first WAIT cycle already counts as cycle 1.
                    cnt <= CNT_W'(1);
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (dec_done) begin
                        rsp_data  <= dec_data_out;
                        rsp_ok    <= dec_valid;
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
                    end
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT)) begin
                        rsp_data    <= '0;
                        rsp_ok      <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt_onehot;
                        state       <= RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        ptr       <= (gnt == IDX_W'(NREQ - 1)) ? '0 : gnt + IDX_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_polar64_dec_arbiter.sv
// Self-checking bench for polar64_dec_arbiter with a latency-programmable stub decoder.
module tb_polar64_dec_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_rx;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready = '0;
    logic [23:0]          rsp_data;
    logic                 rsp_ok;
    logic                 rsp_timeout;
    logic                 dec_start;
    logic [63:0]          dec_rx;
    logic                 dec_done = 1'b0;
    logic [23:0]          dec_data_out = '0;
    logic                 dec_valid = 1'b0;
    logic                 busy;

    logic [63:0]          words_u [NREQ];
    int                   tests = 0;
    int                   fails = 0;
    int                   m_ptr = 0;
    int                   stub_L = 5;
    int                   stub_cnt = 0;
    bit                   stub_never = 1'b0;
    logic [63:0]          stub_word = '0;

    polar64_dec_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rx(req_rx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout),
        .dec_start(dec_start), .dec_rx(dec_rx), .dec_done(dec_done),
        .dec_data_out(dec_data_out), .dec_valid(dec_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) req_rx[64*i +: 64] = words_u[i];
    end

    // Stub decoder behaviour: payload = low ^ mid field, CRC passes when top 16 bits are zero.
    function automatic logic [23:0] ref_data(input logic [63:0] w);
        return w[23:0] ^ w[47:24];
    endfunction

    function automatic logic ref_ok(input logic [63:0] w);
        return (w[63:48] == 16'h0);
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] pend, input int p);
        logic [NREQ-1:0] sh;
        for (int k = 0; k < NREQ; k++) begin
            sh = pend >> ((p + k) % NREQ);
            if (sh[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        dec_done     <= 1'b0;
        dec_data_out <= 24'($urandom);
        dec_valid    <= 1'($urandom);
        if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                dec_done     <= 1'b1;
                dec_data_out <= ref_data(stub_word);
                dec_valid    <= ref_ok(stub_word);
            end
        end
        if (dec_start && !stub_never) begin
            stub_word = dec_rx;
            if (stub_L <= 1) begin
                dec_done     <= 1'b1;
                dec_data_out <= ref_data(stub_word);
                dec_valid    <= ref_ok(stub_word);
            end else begin
                stub_cnt = stub_L - 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; stub_never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; m_ptr = 0;
    endtask

    // Single request from requester r; returns observed timing and response fields.
    task automatic run_one(input int r, input logic [63:0] w, input int lat, input bit nodone,
                           input int bound, output logic [NREQ-1:0] rdy, output int t_start,
                           output int nstart, output int t_rsp, output logic [NREQ-1:0] rv,
                           output logic [23:0] d, output logic ok, output logic to);
        words_u[r] = w; stub_L = lat; stub_never = nodone;
        req_valid = oh(r);
        #1;
        rdy = req_ready;
        t_start = -1; nstart = 0; t_rsp = -1; rv = '0; d = '0; ok = 1'b0; to = 1'b0;
        for (int t = 1; t <= bound; t++) begin
            @(negedge clk);
            if (t == 1) req_valid = '0;
            if (dec_start) begin
                nstart++;
                if (t_start < 0) t_start = t;
            end
            if (rsp_valid != '0) begin
                t_rsp = t; rv = rsp_valid; d = rsp_data; ok = rsp_ok; to = rsp_timeout;
                break;
            end
        end
        if (t_rsp > 0) begin
            rsp_ready = '1;
            @(negedge clk);
            rsp_ready = '0;
            m_ptr = (r + 1) % NREQ;
        end
    endtask

    task automatic test_arbitrate(input logic [NREQ-1:0] mask, input int lat);
        logic [63:0]     w [NREQ];
        logic [NREQ-1:0] pend;
        int              g, t;
        for (int i = 0; i < NREQ; i++) begin
            w[i] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) w[i][63:48] = 16'h0;
            words_u[i] = w[i];
        end
        stub_L = lat; stub_never = 1'b0;
        pend = mask; req_valid = pend;
        while (pend != '0) begin
            g = pick(pend, m_ptr);
            #1;
            tests++;
            if (req_ready !== oh(g)) begin
                fails++; $display("FAIL arb_grant: req_ready=%b expected %b", req_ready, oh(g));
            end
            @(negedge clk);
            pend = pend & ~oh(g); req_valid = pend;
            t = 1;
            while (rsp_valid === '0 && t < lat + 20) begin @(negedge clk); t++; end
            tests++;
            if (rsp_valid !== oh(g)) begin
                fails++; $display("FAIL arb_rsp_valid: rsp_valid=%b expected %b", rsp_valid, oh(g));
            end
            tests++;
            if (t !== lat + 2) begin
                fails++; $display("FAIL arb_latency: cycle %0d expected %0d", t, lat + 2);
            end
            tests++;
            if (rsp_data !== ref_data(w[g]) || rsp_ok !== ref_ok(w[g]) || rsp_timeout !== 1'b0) begin
                fails++;
                $display("FAIL arb_payload: data=%h ok=%b to=%b expected data=%h ok=%b to=0",
                         rsp_data, rsp_ok, rsp_timeout, ref_data(w[g]), ref_ok(w[g]));
            end
            rsp_ready = '1;
            @(negedge clk);
            rsp_ready = '0;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'b1011; rsp_ready = '1;
        repeat (3) @(negedge clk);
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL rst_req_ready: %b expected 0", req_ready); end
        tests++; if (rsp_valid !== '0) begin fails++; $display("FAIL rst_rsp_valid: %b expected 0", rsp_valid); end
        tests++; if (rsp_data !== '0) begin fails++; $display("FAIL rst_rsp_data: %h expected 0", rsp_data); end
        tests++; if (rsp_ok !== 1'b0) begin fails++; $display("FAIL rst_rsp_ok: %b expected 0", rsp_ok); end
        tests++; if (rsp_timeout !== 1'b0) begin fails++; $display("FAIL rst_rsp_timeout: %b expected 0", rsp_timeout); end
        tests++; if (dec_start !== 1'b0) begin fails++; $display("FAIL rst_dec_start: %b expected 0", dec_start); end
        tests++; if (dec_rx !== '0) begin fails++; $display("FAIL rst_dec_rx: %h expected 0", dec_rx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: %b expected 0", busy); end
        req_valid = '0; rsp_ready = '0; rst_n = 1'b1; m_ptr = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: %b expected 0", busy); end
    endtask

    task automatic test_single_clean();
        logic [63:0] w; logic [NREQ-1:0] rdy, rv; logic [23:0] d; logic ok, to;
        int ts, ns, tr;
        w = {40'h0, 24'hABCDEF};
        run_one(0, w, 5, 1'b0, 40, rdy, ts, ns, tr, rv, d, ok, to);
        tests++; if (rdy !== oh(0)) begin fails++; $display("FAIL single_ready: %b expected %b", rdy, oh(0)); end
        tests++; if (ts !== 1) begin fails++; $display("FAIL single_start_cycle: %0d expected 1", ts); end
        tests++; if (ns !== 1) begin fails++; $display("FAIL single_start_count: %0d expected 1", ns); end
        tests++; if (tr !== 7) begin fails++; $display("FAIL single_rsp_cycle: %0d expected 7", tr); end
        tests++; if (rv !== oh(0)) begin fails++; $display("FAIL single_rsp_valid: %b expected %b", rv, oh(0)); end
        tests++; if (d !== 24'hABCDEF) begin fails++; $display("FAIL single_data: %h expected abcdef", d); end
        tests++; if (ok !== 1'b1 || to !== 1'b0) begin fails++; $display("FAIL single_flags: ok=%b to=%b expected ok=1 to=0", ok, to); end
        tests++; if (dec_rx !== w) begin fails++; $display("FAIL single_dec_rx: %h expected %h", dec_rx, w); end
        tests++; if (rsp_data !== 24'hABCDEF) begin fails++; $display("FAIL single_hold: %h expected abcdef", rsp_data); end
    endtask

    task automatic test_round_robin();
        do_reset();
        test_arbitrate(4'b1111, 3);
        test_arbitrate(4'b0101, 2);
    endtask

    task automatic test_uncorrectable();
        logic [63:0] w; logic [NREQ-1:0] rdy, rv; logic [23:0] d; logic ok, to;
        int ts, ns, tr, r;
        r = $urandom_range(0, NREQ - 1);
        w = {$urandom, $urandom}; w[63:48] = 16'hBEEF;
        run_one(r, w, 5, 1'b0, 40, rdy, ts, ns, tr, rv, d, ok, to);
        tests++; if (rdy !== oh(r)) begin fails++; $display("FAIL unc_ready: %b expected %b", rdy, oh(r)); end
        tests++; if (tr !== 7) begin fails++; $display("FAIL unc_rsp_cycle: %0d expected 7", tr); end
        tests++; if (rv !== oh(r)) begin fails++; $display("FAIL unc_rsp_valid: %b expected %b", rv, oh(r)); end
        tests++; if (ok !== 1'b0 || to !== 1'b0 || d !== ref_data(w)) begin
            fails++; $display("FAIL unc_payload: ok=%b to=%b data=%h expected ok=0 to=0 data=%h", ok, to, d, ref_data(w));
        end
    endtask

    task automatic test_timeout_boundary();
        logic [63:0] w; logic [NREQ-1:0] rdy, rv; logic [23:0] d; logic ok, to;
        int ts, ns, tr, r, et; logic eto;
        for (int lat = TIMEOUT; lat <= TIMEOUT + 1; lat++) begin
            r = $urandom_range(0, NREQ - 1);
            w = {16'h0, 16'($urandom), $urandom};
            eto = WDOG && (lat > TIMEOUT);
            et  = eto ? TIMEOUT + 2 : lat + 2;
            run_one(r, w, lat, 1'b0, 60, rdy, ts, ns, tr, rv, d, ok, to);
            tests++; if (tr !== et) begin fails++; $display("FAIL tob_rsp_cycle: L=%0d %0d expected %0d", lat, tr, et); end
            tests++; if (to !== eto) begin fails++; $display("FAIL tob_timeout: L=%0d %b expected %b", lat, to, eto); end
            tests++; if (d !== (eto ? 24'h0 : ref_data(w)) || ok !== (eto ? 1'b0 : 1'b1)) begin
                fails++; $display("FAIL tob_payload: L=%0d data=%h ok=%b", lat, d, ok);
            end
        end
    endtask

    task automatic test_missing_done();
        logic [63:0] w; logic [NREQ-1:0] rdy, rv; logic [23:0] d; logic ok, to;
        int ts, ns, tr, r;
        r = $urandom_range(0, NREQ - 1);
        w = {$urandom, $urandom};
        run_one(r, w, 0, 1'b1, 100, rdy, ts, ns, tr, rv, d, ok, to);
        tests++; if (ns !== 1) begin fails++; $display("FAIL nodone_start_count: %0d expected 1", ns); end
`ifdef POLAR_DEC_ARB_TIMEOUT_EN
        tests++; if (tr !== TIMEOUT + 2) begin fails++; $display("FAIL nodone_rsp_cycle: %0d expected %0d", tr, TIMEOUT + 2); end
        tests++; if (rv !== oh(r)) begin fails++; $display("FAIL nodone_rsp_valid: %b expected %b", rv, oh(r)); end
        tests++; if (to !== 1'b1 || d !== 24'h0 || ok !== 1'b0) begin
            fails++; $display("FAIL nodone_payload: to=%b data=%h ok=%b expected to=1 data=0 ok=0", to, d, ok);
        end
        tests++; if (rsp_timeout !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL nodone_after: rsp_timeout=%b busy=%b expected 1 0", rsp_timeout, busy);
        end
`else
        tests++; if (tr !== -1) begin fails++; $display("FAIL nodone_no_rsp: response at %0d expected none", tr); end
        tests++; if (busy !== 1'b1 || rsp_valid !== '0) begin
            fails++; $display("FAIL nodone_stuck: busy=%b rsp_valid=%b expected 1 0", busy, rsp_valid);
        end
        do_reset();
`endif
        stub_never = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] w; int r, t;
        r = $urandom_range(0, NREQ - 1);
        w = {$urandom, $urandom};
        words_u[r] = w; stub_L = 3; stub_never = 1'b0;
        req_valid = oh(r);
        @(negedge clk);
        req_valid = '0;
        t = 1;
        while (rsp_valid === '0 && t < 30) begin @(negedge clk); t++; end
        tests++; if (t !== 5) begin fails++; $display("FAIL bp_rsp_cycle: %0d expected 5", t); end
        req_valid = ~oh(r); rsp_ready = ~oh(r);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++; if (rsp_valid !== oh(r)) begin fails++; $display("FAIL bp_rsp_valid: %b expected %b", rsp_valid, oh(r)); end
            tests++; if (rsp_data !== ref_data(w)) begin fails++; $display("FAIL bp_rsp_data: %h expected %h", rsp_data, ref_data(w)); end
            tests++; if (dec_start !== 1'b0) begin fails++; $display("FAIL bp_dec_start: %b expected 0", dec_start); end
            tests++; if (req_ready !== '0) begin fails++; $display("FAIL bp_req_ready: %b expected 0", req_ready); end
        end
        req_valid = '0; rsp_ready = oh(r);
        @(negedge clk);
        rsp_ready = '0;
        m_ptr = (r + 1) % NREQ;
        tests++; if (rsp_valid !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL bp_release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        words_u[2] = {$urandom, $urandom}; stub_L = 12; stub_never = 1'b0;
        req_valid = oh(2);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: %b expected 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || dec_start !== 1'b0) begin
            fails++; $display("FAIL mid_ctrl: busy=%b rsp_valid=%b req_ready=%b dec_start=%b expected all 0",
                              busy, rsp_valid, req_ready, dec_start);
        end
        tests++; if (dec_rx !== '0 || rsp_data !== '0 || rsp_ok !== 1'b0 || rsp_timeout !== 1'b0) begin
            fails++; $display("FAIL mid_data: dec_rx=%h rsp_data=%h ok=%b to=%b expected all 0",
                              dec_rx, rsp_data, rsp_ok, rsp_timeout);
        end
        rst_n = 1'b1; m_ptr = 0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL mid_stale_done: %0d active cycles expected 0", seen); end
        test_arbitrate(4'b1001, 2);
    endtask

    task automatic test_back_to_back();
        test_arbitrate(4'b1111, 1);
        for (int i = 0; i < 12; i++) begin
            test_arbitrate(4'($urandom_range(1, 15)), $urandom_range(1, 8));
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) words_u[i] = '0;
        test_reset();
        test_single_clean();
        test_round_robin();
        test_uncorrectable();
        test_timeout_boundary();
        test_missing_done();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
